// File: rtl/hpc2_sched_pkg.sv
// Shared definitions for the HPC2 gadget scheduler: randomness sizing, tag format and limits.
package hpc2_sched_pkg;

   localparam int unsigned NREQ_MAX    = 16;
   localparam int unsigned LATENCY_MAX = 4;
   localparam int unsigned ID_W        = $clog2(NREQ_MAX);

   // Fresh random bits consumed by one HPC2 AND/NAND at masking order d.
   function automatic int unsigned hpc2_rnd_bits(input int unsigned d);
      return d * (d + 1) / 2;
   endfunction

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or above ptr, wrapping around.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]                        req,
   input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
   input  logic                                en,
   output logic [N-1:0]                        gnt,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx
);

   localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

   logic        found;
   int unsigned j;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = (32'(ptr) + k) % N;
         if (en && !found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = W'(j);
         end
      end
   end

endmodule

// File: rtl/hpc2_gadget_scheduler.sv
// Shares one pipelined HPC2 masked NAND gadget among NREQ requesters, one issue per cycle,
// pairing each issue with one fresh randomness word and routing results back by tag.
module hpc2_gadget_scheduler
   import hpc2_sched_pkg::*;
#(
   parameter int unsigned security_order = 1,
   parameter int unsigned NREQ           = 4,
   parameter int unsigned LATENCY        = 1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NREQ-1:0]                          req_valid,
   output logic [NREQ-1:0]                          req_ready,
   input  logic [NREQ*(security_order+1)-1:0]       req_a,
   input  logic [NREQ*(security_order+1)-1:0]       req_b,
   input  logic                                     rnd_valid,
   output logic                                     rnd_ready,
   input  logic [hpc2_rnd_bits(security_order)-1:0] rnd_in,
   output logic [security_order:0]                  g_a,
   output logic [security_order:0]                  g_b,
   output logic [hpc2_rnd_bits(security_order)-1:0] g_r,
   input  logic [security_order:0]                  g_c,
   output logic [NREQ-1:0]                          rsp_valid,
   output logic [security_order:0]                  rsp_c
);

   localparam int unsigned SH  = security_order + 1;
   localparam int unsigned RND = hpc2_rnd_bits(security_order);
   localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   ptr;
   logic [PW-1:0]   ptr_nxt;
   logic [NREQ-1:0] gnt;
   logic [PW-1:0]   gnt_idx;
   logic            issue;
   tag_t            pipe [LATENCY];
   tag_t            last;

   // Gating the arbiter with rnd_valid keeps req_ready low whenever randomness is missing.
   rr_arbiter #(
      .N (NREQ)
   ) u_arb (
      .req (req_valid),
      .ptr (ptr),
      .en  (rnd_valid & ~rst),
      .gnt (gnt),
      .idx (gnt_idx)
   );

   always_comb begin
      issue     = |gnt;
      req_ready = gnt;
      rnd_ready = issue;
      g_a       = issue ? req_a[gnt_idx*SH +: SH] : '0;
      g_b       = issue ? req_b[gnt_idx*SH +: SH] : '0;
      g_r       = issue ? rnd_in : RND'(0);
      ptr_nxt   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
         for (int unsigned s = 0; s < LATENCY; s++) begin
            pipe[s] <= '0;
         end
      end else begin
         pipe[0] <= '{valid: issue, id: ID_W'(gnt_idx)};
         for (int unsigned s = 1; s < LATENCY; s++) begin
            pipe[s] <= pipe[s-1];
         end
         if (issue) begin
            ptr <= ptr_nxt;
         end
      end
   end

   always_comb begin
      last      = pipe[LATENCY-1];
      rsp_valid = last.valid ? (NREQ'(1) << last.id) : '0;
      rsp_c     = last.valid ? g_c : '0;
   end

endmodule

// File: doc/hpc2_gadget_scheduler.md
# hpc2_gadget_scheduler

Time-multiplexes one pipelined masked NAND gadget (HPC2, any security order) among `NREQ` requesters. Each requester offers a shared operand pair through a valid/ready handshake. The scheduler grants one requester per cycle in round-robin order and pairs the grant with one fresh randomness word from the randomness-source handshake. It tracks every in-flight operation through the gadget's pipeline and returns each masked result to its owner. The block sits between the masked S-box or round logic and a single shared gadget instance plus the PRNG.

## Interface
Parameters:
- `security_order`, 1: masking order d; shares per operand = d+1.
- `NREQ`, 4: number of requesters, 2..16.
- `LATENCY`, 1: gadget latency in cycles from input to `g_c`, 1..4.
- `RND`, d(d+1)/2 (derived, localparam): randomness bits per gadget operation.

Ports (clock and reset first):
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, NREQ: per-requester operation request.
- `req_ready`, out, NREQ: one-hot grant; the handshake completes when `req_valid[i] & req_ready[i]`.
- `req_a`, in, NREQ*(d+1): operand a shares; requester i occupies slice [i*(d+1) +: d+1].
- `req_b`, in, NREQ*(d+1): operand b shares, same packing as `req_a`.
- `rnd_valid`, in, 1: a randomness word is available.
- `rnd_ready`, out, 1: randomness consumed this cycle.
- `rnd_in`, in, RND: fresh randomness word.
- `g_a`, out, d+1: operand a shares driven to the gadget.
- `g_b`, out, d+1: operand b shares driven to the gadget.
- `g_r`, out, RND: randomness driven to the gadget.
- `g_c`, in, d+1: gadget output shares (masked NAND).
- `rsp_valid`, out, NREQ: one-hot result strobe; there is no backpressure.
- `rsp_c`, out, d+1: result shares, valid while any `rsp_valid` bit is set.

## Operation
- Issue condition: issue = `rnd_valid` & (|`req_valid`). At most one issue per cycle.
- Arbitration:
  - Round-robin pointer `ptr` (log2 NREQ bits).
  - Grant the first requester with `req_valid` set, scanning from `ptr` upward with wrap-around.
  - On issue, `ptr` <= granted index + 1, modulo NREQ.
  - With no issue, `ptr` holds.
- On issue, all of the following happen in the same cycle:
  - `req_ready[g]`=1 and `rnd_ready`=1.
  - `g_a`/`g_b` = the granted requester's slices.
  - `g_r` = `rnd_in`.
- No issue:
  - `req_ready`=0 and `rnd_ready`=0.
  - `g_a`, `g_b` and `g_r` are all driven to zero. Stale shares are never held on the gadget inputs.
- `req_ready` and `rnd_ready` are combinational from the valids and `ptr`. `req_ready` never asserts without `rnd_valid`.
- Randomness is never reused. Each rnd word is consumed by exactly one issue.
- Tag pipeline:
  - LATENCY-deep shift register of {valid, id}.
  - Stage 0 loads {issue, g}; each stage advances every cycle.
  - The last stage drives `rsp_valid` = valid ? onehot(id) : 0.
  - `rsp_c` = `g_c` when the last stage is valid, else zero.
- Ordering: results return in issue order. The full pipeline sustains one result per cycle.
- A requester may hold `req_valid` across grants; every grant is a new operation.
- Operands must be stable only during the grant cycle.

## Timing
- Reset values:
  - `ptr`=0 and all tag stages invalid.
  - Hence `rsp_valid`=0 and `rsp_c`=0 from the cycle after `rst` is sampled high.
  - `req_ready`/`rnd_ready`=0 while `rst`=1.
  - `g_*`=0 while `rst`=1.
- Latency: an issue in cycle t gives `rsp_valid` in cycle t+LATENCY.
- Throughput: one operation per cycle while `rnd_valid` stays high.
- A `rnd_valid` drop stalls issue only. In-flight operations still complete.
- Reset mid-operation: all in-flight tags are discarded and no response is emitted for them. The first issue after reset goes to the lowest valid index.
- Simultaneous issue and response in the same cycle are independent.
- Single requester: it is granted every cycle that `rnd_valid`=1.

## Structure
- Package `hpc2_sched_pkg` holds:
  - the function `hpc2_rnd_bits(d)` = d(d+1)/2;
  - the tag struct {valid, id};
  - the limits NREQ_MAX=16 and LATENCY_MAX=4.
- Sub-module `rr_arbiter` (parameter N):
  - inputs: request vector, pointer, enable;
  - outputs: one-hot grant and binary index.
- The gadget is instantiated outside this block.

## Test plan
- Reset, then NREQ=4 with all requesters valid and `rnd_valid`=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3. `rsp_valid` follows the same order delayed by LATENCY.
- `rnd_valid`=0 with requests pending -> `req_ready`=0 and `g_a`/`g_b`/`g_r`=0. Raise `rnd_valid` -> issue in the same cycle.
- d=1, requester 2 sends a shares {1,0} and b shares {1,1} (a=1, b=0); the bench recombines `rsp_c` -> unmasked value 1. Check with 16 random operand pairs and all four unmasked cases.
- Assert `rst` one cycle after three back-to-back issues -> no `rsp_valid` pulse afterwards, and `ptr` restarts at 0.
- Only requester 3 valid for 5 cycles with `rnd_valid` toggling 1,0,1,1,0 -> exactly 3 grants and 3 `rnd_ready` pulses. Three responses return, each at issue cycle + LATENCY.
- Scoreboard assertion over 10k random cycles:
  - every `rnd_ready` pulse coincides with exactly one grant;
  - the count of `rsp_valid` pulses equals the issue count;
  - no result is ever lost.
